// File: rtl/history_reader.sv
// End-of-day playback sequencer for the hourly history RAM: walks addresses 0..NUM_ENTRIES-1,
// one entry per tick, presenting each entry to the display and tracking the busiest hour.
module history_reader #(
   parameter int ADDR_W      = 4,
   parameter int DATA_W      = 4,
   parameter int NUM_ENTRIES = 8,
   parameter int RD_LAT      = 1
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic              abort,
   input  logic              tick,
   input  logic              loop,
   output logic [ADDR_W-1:0] rd_addr,
   input  logic [DATA_W-1:0] rd_data,
   output logic [ADDR_W-1:0] disp_addr,
   output logic [DATA_W-1:0] disp_val,
   output logic              disp_valid,
   output logic [ADDR_W-1:0] peak_addr,
   output logic [DATA_W-1:0] peak_val,
   output logic              busy,
   output logic              done
);

   localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NUM_ENTRIES - 1);
   localparam logic [1:0]        CNT_LAST  = 2'(RD_LAT);

   typedef enum logic [1:0] {
      IDLE,
      FETCH,
      SHOW,
      DONE
   } state_t;

   state_t              state, state_next;
   logic [1:0]          fetch_cnt, cnt_next;
   logic [ADDR_W-1:0]   addr_next, daddr_next, paddr_next;
   logic [DATA_W-1:0]   dval_next, pval_next;
   logic                dvalid_next;
   logic                peak_seen, seen_next;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state      <= IDLE;
         fetch_cnt  <= '0;
         rd_addr    <= '0;
         disp_addr  <= '0;
         disp_val   <= '0;
         disp_valid <= 1'b0;
         peak_addr  <= '0;
         peak_val   <= '0;
         peak_seen  <= 1'b0;
         busy       <= 1'b0;
         done       <= 1'b0;
      end else begin
         state      <= state_next;
         fetch_cnt  <= cnt_next;
         rd_addr    <= addr_next;
         disp_addr  <= daddr_next;
         disp_val   <= dval_next;
         disp_valid <= dvalid_next;
         peak_addr  <= paddr_next;
         peak_val   <= pval_next;
         peak_seen  <= seen_next;
         busy       <= (state_next == FETCH) || (state_next == SHOW);
         done       <= (state_next == DONE);
      end
   end

   // peak_seen forces the first capture of a pass to load the peak even when the value is 0.
   always_comb begin
      state_next  = state;
      cnt_next    = fetch_cnt;
      addr_next   = rd_addr;
      daddr_next  = disp_addr;
      dval_next   = disp_val;
      dvalid_next = disp_valid;
      paddr_next  = peak_addr;
      pval_next   = peak_val;
      seen_next   = peak_seen;

      if (abort) begin
         state_next  = IDLE;
         addr_next   = '0;
         dvalid_next = 1'b0;
      end else begin
         case (state)
            IDLE, DONE: begin
               if (start) begin
                  state_next  = FETCH;
                  addr_next   = '0;
                  cnt_next    = '0;
                  dvalid_next = 1'b0;
                  paddr_next  = '0;
                  pval_next   = '0;
                  seen_next   = 1'b0;
               end
            end
            FETCH: begin
               if (fetch_cnt == CNT_LAST) begin
                  state_next  = SHOW;
                  daddr_next  = rd_addr;
                  dval_next   = rd_data;
                  dvalid_next = 1'b1;
                  seen_next   = 1'b1;
                  if (!peak_seen || (rd_data > peak_val)) begin
                     paddr_next = rd_addr;
                     pval_next  = rd_data;
                  end
               end else begin
                  cnt_next = fetch_cnt + 2'd1;
               end
            end
            SHOW: begin
               if (tick) begin
                  if (rd_addr >= LAST_ADDR) begin
                     if (loop) begin
                        state_next = FETCH;
                        addr_next  = '0;
                        cnt_next   = '0;
                     end else begin
                        state_next = DONE;
                     end
                  end else begin
                     state_next = FETCH;
                     addr_next  = rd_addr + 1'b1;
                     cnt_next   = '0;
                  end
               end
            end
            default: state_next = IDLE;
         endcase
      end
   end

endmodule
